// File: rtl/key_pkg.sv
// key_pkg: shared sizes, calculator key-bit names and index helpers for the
// 4x4 keypad scanner. Used by key_matrix_scan and its testbench.
package key_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int NUM_KEYS = 16;

    // Bit positions of each calculator key in key_out / key_pulse
    localparam int KEY_1   = 0;
    localparam int KEY_2   = 1;
    localparam int KEY_3   = 2;
    localparam int KEY_ADD = 3;
    localparam int KEY_4   = 4;
    localparam int KEY_5   = 5;
    localparam int KEY_6   = 6;
    localparam int KEY_SUB = 7;
    localparam int KEY_7   = 8;
    localparam int KEY_8   = 9;
    localparam int KEY_9   = 10;
    localparam int KEY_MUL = 11;
    localparam int KEY_0   = 12;
    localparam int KEY_CLR = 13;
    localparam int KEY_EQ  = 14;
    localparam int KEY_DIV = 15;

    typedef logic [NUM_KEYS-1:0] key_vec_t;
    typedef logic [NUM_ROWS-1:0] row_vec_t;
    typedef logic [NUM_COLS-1:0] col_vec_t;
    typedef logic [1:0]          row_idx_t;

    // Key bit index for a given row/column position
    function automatic int key_idx(input int row, input int col);
        return row * NUM_COLS + col;
    endfunction

    // Active-low row drive pattern with exactly one row pulled low
    function automatic row_vec_t row_drive(input row_idx_t idx);
        return ~(row_vec_t'(1) << idx);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: one key's integrating debouncer. A key changes state only
// after DEBOUNCE_SCANS consecutive samples disagree with its current level;
// any agreeing sample restarts the count. Optional release edge output is
// built only when KEY_RELEASE_PULSE_EN is defined.
module key_debounce #(
    parameter int DEBOUNCE_SCANS = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_en,
    input  logic raw,
    output logic level,
    output logic rise
`ifdef KEY_RELEASE_PULSE_EN
    ,
    output logic fall
`endif
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       level_q;
    logic       level_d;
    logic       rise_q;
    logic       rise_d;
`ifdef KEY_RELEASE_PULSE_EN
    logic       fall_q;
    logic       fall_d;
`endif

    // Next-state: count disagreeing samples, toggle level when the count completes
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
`ifdef KEY_RELEASE_PULSE_EN
        fall_d  = 1'b0;
`endif
        if (sample_en) begin
            if (raw == level_q) begin
                cnt_d = 4'd0;
            end else if (cnt_q == 4'(DEBOUNCE_SCANS - 1)) begin
                cnt_d   = 4'd0;
                level_d = ~level_q;
                rise_d  = ~level_q;
`ifdef KEY_RELEASE_PULSE_EN
                fall_d  = level_q;
`endif
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    // State registers; edge flags are registered alongside the level so they align
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= 4'd0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
`ifdef KEY_RELEASE_PULSE_EN
            fall_q  <= 1'b0;
`endif
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
`ifdef KEY_RELEASE_PULSE_EN
            fall_q  <= fall_d;
`endif
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
`ifdef KEY_RELEASE_PULSE_EN
    assign fall  = fall_q;
`endif

endmodule

// File: rtl/key_matrix_scan.sv
// key_matrix_scan: scans the 4x4 calculator keypad one row per SCAN_DIV
// cycles, synchronises the asynchronous column inputs, and debounces each of
// the 16 keys independently. Define KEY_RELEASE_PULSE_EN to add the
// key_release output.
module key_matrix_scan
    import key_pkg::*;
#(
    parameter int SCAN_DIV       = 12000,
    parameter int DEBOUNCE_SCANS = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_COLS-1:0] col,
    output logic [NUM_ROWS-1:0] row,
    output logic [NUM_KEYS-1:0] key_out,
    output logic [NUM_KEYS-1:0] key_pulse
`ifdef KEY_RELEASE_PULSE_EN
    ,
    output logic [NUM_KEYS-1:0] key_release
`endif
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    col_vec_t   col_meta_q;
    col_vec_t   col_meta_d;
    col_vec_t   col_s_q;
    col_vec_t   col_s_d;
    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;
    row_idx_t   row_idx_q;
    row_idx_t   row_idx_d;
    row_vec_t   row_q;
    row_vec_t   row_d;
    logic       sample_cycle;
    row_vec_t   sample_en;
    key_vec_t   level_vec;
    key_vec_t   rise_vec;
`ifdef KEY_RELEASE_PULSE_EN
    key_vec_t   fall_vec;
`endif

    // Divider, row pointer and per-row sample strobes; row drive follows the pointer's next value
    always_comb begin
        col_meta_d   = col;
        col_s_d      = col_meta_q;
        sample_cycle = (div_cnt_q == DIV_W'(SCAN_DIV - 1));
        div_cnt_d    = sample_cycle ? '0 : div_cnt_q + DIV_W'(1);
        row_idx_d    = sample_cycle ? row_idx_q + 2'd1 : row_idx_q;
        row_d        = row_drive(row_idx_d);
        sample_en    = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            sample_en[r] = sample_cycle && (row_idx_q == row_idx_t'(r));
        end
    end

    // Scan timing and two-flop column synchroniser; columns idle high
    always_ff @(posedge clk) begin
        if (rst) begin
            col_meta_q <= 4'hF;
            col_s_q    <= 4'hF;
            div_cnt_q  <= '0;
            row_idx_q  <= 2'd0;
            row_q      <= 4'b1110;
        end else begin
            col_meta_q <= col_meta_d;
            col_s_q    <= col_s_d;
            div_cnt_q  <= div_cnt_d;
            row_idx_q  <= row_idx_d;
            row_q      <= row_d;
        end
    end

    // One debouncer per key; a key only sees samples taken while its own row is driven
    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
        for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
            localparam int K = key_idx(r, c);
            key_debounce #(
                .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
            ) u_debounce (
                .clk       (clk),
                .rst       (rst),
                .sample_en (sample_en[r]),
                .raw       (~col_s_q[c]),
                .level     (level_vec[K]),
                .rise      (rise_vec[K])
`ifdef KEY_RELEASE_PULSE_EN
                ,
                .fall      (fall_vec[K])
`endif
            );
        end
    end

    assign row       = row_q;
    assign key_out   = level_vec;
    assign key_pulse = rise_vec;
`ifdef KEY_RELEASE_PULSE_EN
    assign key_release = fall_vec;
`endif

endmodule

// File: tb/tb_key_matrix_scan.sv
// tb_key_matrix_scan: directed bench for key_matrix_scan with SCAN_DIV=4 and
// DEBOUNCE_SCANS=3 (16-cycle scan). Expected press/release pulses go into
// scoreboard queues when keys are driven and are popped by a monitor
// whenever the DUT pulses. Define KEY_RELEASE_PULSE_EN to cover key_release.
module tb_key_matrix_scan;
    import key_pkg::*;

    localparam int SD = 4;
    localparam int DB = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [15:0] key_out;
    logic [15:0] key_pulse;
`ifdef KEY_RELEASE_PULSE_EN
    logic [15:0] key_release;
`endif

    logic [15:0] pressed = 16'h0;
    logic [15:0] exp_level = 16'h0;
    logic [15:0] pulse_q[$];
    logic [15:0] rel_q[$];
    logic [15:0] mon_exp;
    logic [15:0] rel_exp;
    bit          mon_en = 1'b0;
    int          assert_cnt = 0;
    int          fail_cnt = 0;

    always #5 clk = ~clk;

    key_matrix_scan #(
        .SCAN_DIV(SD),
        .DEBOUNCE_SCANS(DB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .col       (col),
        .row       (row),
        .key_out   (key_out),
        .key_pulse (key_pulse)
`ifdef KEY_RELEASE_PULSE_EN
        ,
        .key_release (key_release)
`endif
    );

    // Keypad model: a pressed key pulls its column low only while its row is driven low
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (row[r] == 1'b0 && pressed[r*4+c]) col[c] = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        assert_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] new_pressed);
        pressed = new_pressed;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Stop on the negedge of the first cycle of a scan (row 0 just driven)
    task automatic waitScanStart();
        logic [3:0] last;
        bit found;
        found = 1'b0;
        last = row;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (row == 4'b1110 && last != 4'b1110) begin
                found = 1'b1;
                break;
            end
            last = row;
        end
        checkOutput("scan_start", {15'b0, found}, 16'h0001);
    endtask

    // Change the held keys (all in row row_n) at a scan start and check the exact edge cycle
    task automatic strokeKeys(input string tag, input logic [15:0] newp, input int row_n);
        logic [15:0] rises;
        logic [15:0] falls;
        rises = newp & ~exp_level;
        falls = exp_level & ~newp;
        waitScanStart();
        if (rises != 16'h0) pulse_q.push_back(rises);
`ifdef KEY_RELEASE_PULSE_EN
        if (falls != 16'h0) rel_q.push_back(falls);
`endif
        applyStimulus(newp);
        tick(4*row_n + 35);
        checkOutput({tag, "_early"}, key_out, exp_level);
        tick(1);
        exp_level = newp;
        checkOutput({tag, "_level"}, key_out, exp_level);
        checkOutput({tag, "_pulse"}, key_pulse, rises);
`ifdef KEY_RELEASE_PULSE_EN
        checkOutput({tag, "_release"}, key_release, falls);
`endif
        if (falls == 16'h0 && rises == 16'h0) checkOutput({tag, "_noop"}, newp, exp_level);
    endtask

    // Scoreboard monitor: every nonzero pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (mon_en) begin
            if (key_pulse !== 16'h0) begin
                mon_exp = (pulse_q.size() > 0) ? pulse_q.pop_front() : 16'h0;
                checkOutput("key_pulse_sb", key_pulse, mon_exp);
            end
`ifdef KEY_RELEASE_PULSE_EN
            if (key_release !== 16'h0) begin
                rel_exp = (rel_q.size() > 0) ? rel_q.pop_front() : 16'h0;
                checkOutput("key_release_sb", key_release, rel_exp);
            end
`endif
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] row_seq [4];
        row_seq[0] = 4'b1110;
        row_seq[1] = 4'b1101;
        row_seq[2] = 4'b1011;
        row_seq[3] = 4'b0111;

        // Reset held for 3 cycles
        rst = 1'b1;
        applyStimulus(16'h0);
        tick(3);
        checkOutput("rst_row", {12'b0, row}, 16'h000E);
        checkOutput("rst_key_out", key_out, 16'h0);
        checkOutput("rst_key_pulse", key_pulse, 16'h0);
`ifdef KEY_RELEASE_PULSE_EN
        checkOutput("rst_key_release", key_release, 16'h0);
`endif
        rst = 1'b0;
        mon_en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            checkOutput("row_cycle", {12'b0, row}, {12'b0, row_seq[k/4]});
            tick(1);
        end

        // Single press and release of '5'
        strokeKeys("k5_press", 16'h0001 << KEY_5, 1);
        strokeKeys("k5_release", 16'h0, 1);

        // Bounce on '=' alternating every scan must never register
        for (int i = 0; i < 10; i++) begin
            waitScanStart();
            applyStimulus((i % 2 == 0) ? 16'h4000 : 16'h0000);
            checkOutput("bounce_level", key_out, 16'h0);
        end
        strokeKeys("eq_hold", 16'h4000, 3);
        strokeKeys("eq_release", 16'h0, 3);

        // Two keys in the same row together
        strokeKeys("k13_press", 16'h0005, 0);
        strokeKeys("k13_release", 16'h0, 0);

        // Reset while 'C' is held: cleared at once, then re-detected as a new press
        strokeKeys("clr_press", 16'h2000, 3);
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        exp_level = 16'h0;
        checkOutput("midrst_key_out", key_out, 16'h0);
        checkOutput("midrst_row", {12'b0, row}, 16'h000E);
        pulse_q.push_back(16'h2000);
        tick(47);
        checkOutput("clr_repress_early", key_out, 16'h0);
        tick(1);
        checkOutput("clr_repress_level", key_out, 16'h2000);
        checkOutput("clr_repress_pulse", key_pulse, 16'h2000);
        exp_level = 16'h2000;
        strokeKeys("clr_release", 16'h0, 3);

        // Press and release '/'; release edge pulse checked when present
        strokeKeys("div_press", 16'h8000, 3);
        strokeKeys("div_release", 16'h0, 3);

        tick(20);
        checkOutput("pulse_queue_empty", 16'(pulse_q.size()), 16'h0);
        checkOutput("release_queue_empty", 16'(rel_q.size()), 16'h0);
        checkOutput("final_key_out", key_out, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
